// File: rtl/clk_div_prog.sv
// Clock-enable divider: power-of-two output chain plus a runtime-programmable
// integer divider whose ratio changes only at period boundaries.
module clk_div_prog #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  div_val,
  input  logic              div_load,
  output logic              div_busy,
  output logic              div_err,
  output logic              clk_div,
  output logic              tick,
  output logic [STAGES-1:0] clk_pow2
);

  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } load_state_e;

  load_state_e       r_state;
  load_state_e       w_state_next;
  logic [STAGES-1:0] r_pow_cnt;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_cur_div;
  logic [WIDTH-1:0]  r_pend_div;
  logic              r_err;
  logic              r_clk_div;
  logic              r_tick;

  logic              w_load_ok;
  logic              w_load_bad;
  logic              w_wrap;
  logic              w_apply;
  logic [WIDTH-1:0]  w_cnt_next;
  logic [WIDTH-1:0]  w_cur_next;
  logic [WIDTH-1:0]  w_pend_next;
  logic              w_clk_div_next;

  assign w_load_ok  = div_load && (div_val >= DIV_MIN);
  assign w_load_bad = div_load && (div_val < DIV_MIN);
  assign w_wrap     = en && (r_cnt == (r_cur_div - ONE));
  // The wrap sees the pending state from before this edge; a load on the
  // same edge is captured and waits for the following wrap.
  assign w_apply    = w_wrap && (r_state == ST_PEND);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_load_ok) w_state_next = ST_PEND;
      ST_PEND: if (w_apply && !w_load_ok) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cur_next     = r_cur_div;
    w_pend_next    = r_pend_div;
    w_cnt_next     = r_cnt;
    w_clk_div_next = r_clk_div;
    if (w_apply)   w_cur_next  = r_pend_div;
    if (w_load_ok) w_pend_next = div_val;
    if (en) begin
      w_cnt_next     = w_wrap ? '0 : (r_cnt + ONE);
      w_clk_div_next = (w_cnt_next >= (w_cur_next >> 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pow_cnt  <= '0;
      r_cnt      <= '0;
      r_cur_div  <= DIV_MIN;
      r_pend_div <= DIV_MIN;
      r_err      <= 1'b0;
      r_clk_div  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cur_div  <= w_cur_next;
      r_pend_div <= w_pend_next;
      r_err      <= w_load_bad;
      r_clk_div  <= w_clk_div_next;
      r_tick     <= w_wrap;
      if (en) r_pow_cnt <= r_pow_cnt + STAGES'(1);
    end
  end

  assign div_busy = (r_state == ST_PEND);
  assign div_err  = r_err;
  assign clk_div  = r_clk_div;
  assign tick     = r_tick;
  assign clk_pow2 = r_pow_cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: every output compared each cycle against a
// period-script model, plus directed period/duty measurements.
module tb_clk_div_prog;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;

  logic              clk;
  logic              reset;
  logic              en;
  logic [WIDTH-1:0]  div_val;
  logic              div_load;
  logic              div_busy;
  logic              div_err;
  logic              clk_div;
  logic              tick;
  logic [STAGES-1:0] clk_pow2;

  int checks;
  int failures;

  clk_div_prog #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_div  (clk_div),
    .tick     (tick),
    .clk_pow2 (clk_pow2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // reference model: each divide period is a script of {clk_div, tick}
  // samples, one per enabled edge, built from the active ratio.
  logic [1:0]        exp_q[$];
  int                m_n;
  int                m_pend;
  bit                m_busy;
  bit                m_err;
  bit                m_clk;
  bit                m_tick;
  logic [STAGES-1:0] m_pow;

  task automatic model_reset();
    exp_q.delete();
    m_n = 2; m_pend = 2; m_busy = 0; m_err = 0; m_clk = 0; m_tick = 0; m_pow = '0;
  endtask

  task automatic model_edge(input bit e, input bit ld, input int v);
    logic [1:0] s;
    m_err  = ld && (v < 2);
    m_tick = 0;
    if (e) begin
      if (exp_q.size() == 0)
        for (int k = 1; k <= m_n; k++)
          exp_q.push_back({(k < m_n) && (k >= m_n / 2), k == m_n});
      s      = exp_q.pop_front();
      m_clk  = s[1];
      m_tick = s[0];
      m_pow  = m_pow + 1'b1;
      if (m_tick && m_busy) begin
        m_n    = m_pend;
        m_busy = 0;
      end
    end
    if (ld && v >= 2) begin
      m_pend = v;
      m_busy = 1;
    end
  endtask

  function automatic logic [STAGES+3:0] exp_vec();
    return {m_busy, m_err, m_clk, m_tick, m_pow};
  endfunction

  function automatic logic [STAGES+3:0] got_vec();
    return {div_busy, div_err, clk_div, tick, clk_pow2};
  endfunction

  // driver: inputs change 1 ns after a posedge, outputs are sampled there too
  task automatic step(input bit e, input bit ld, input int v);
    en       = e;
    div_load = ld;
    div_val  = WIDTH'(v);
    @(posedge clk);
    model_edge(e, ld, v);
    #1;
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (got_vec() !== '0) begin
        failures++;
        $display("FAIL reset_state got=%b exp=%b", got_vec(), {(STAGES+4){1'b0}});
      end
    end
    reset = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step(1, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pow2_default cyc=%0d got=%b exp=%b", c, got_vec(), exp_vec());
      end
      if (c <= 2) begin
        checks++;
        if (tick !== (c == 2)) begin
          failures++;
          $display("FAIL first_tick cyc=%0d got=%b exp=%b", c, tick, c == 2);
        end
      end
    end
  endtask

  task automatic test_load5();
    int guard;
    int ticks;
    step(1, 1, 5);
    checks++;
    if (div_busy !== 1'b1) begin
      failures++;
      $display("FAIL load5_busy got=%b exp=1", div_busy);
    end
    guard = 0;
    while (div_busy === 1'b1 && guard < 10) begin
      step(1, 0, 0);
      guard++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL load5_wait got=%b exp=%b", got_vec(), exp_vec());
      end
    end
    checks++;
    if (div_busy !== 1'b0) begin
      failures++;
      $display("FAIL load5_busy_timeout got=%b exp=0", div_busy);
    end
    ticks = 0;
    for (int c = 0; c < 15; c++) begin
      step(1, 0, 0);
      if (tick === 1'b1) ticks++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL load5_run cyc=%0d got=%b exp=%b", c, got_vec(), exp_vec());
      end
    end
    checks++;
    if (ticks !== 3) begin
      failures++;
      $display("FAIL load5_ticks got=%0d exp=3", ticks);
    end
  endtask

  task automatic test_sweep();
    int ns[3] = '{3, 4, 7};
    int guard, ticks, ones, n;
    foreach (ns[i]) begin
      n = ns[i];
      step(1, 1, n);
      guard = 0;
      while (div_busy === 1'b1 && guard < 20) begin
        step(1, 0, 0);
        guard++;
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL sweep_wait n=%0d got=%b exp=%b", n, got_vec(), exp_vec());
        end
      end
      checks++;
      if (div_busy !== 1'b0) begin
        failures++;
        $display("FAIL sweep_busy_timeout n=%0d got=%b exp=0", n, div_busy);
      end
      ticks = 0; ones = 0;
      for (int c = 0; c < 10 * n; c++) begin
        step(1, 0, 0);
        if (tick === 1'b1) ticks++;
        if (clk_div === 1'b1) ones++;
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL sweep_run n=%0d cyc=%0d got=%b exp=%b", n, c, got_vec(), exp_vec());
        end
      end
      checks++;
      if (ticks !== 10) begin
        failures++;
        $display("FAIL sweep_period n=%0d got=%0d exp=10", n, ticks);
      end
      checks++;
      if (ones !== 10 * ((n + 1) / 2)) begin
        failures++;
        $display("FAIL sweep_duty n=%0d got=%0d exp=%0d", n, ones, 10 * ((n + 1) / 2));
      end
    end
  endtask

  task automatic test_last_wins();
    int guard, gap;
    step(1, 1, 9);
    step(1, 1, 6);
    step(1, 1, 1);
    checks++;
    if ({div_err, div_busy} !== 2'b11) begin
      failures++;
      $display("FAIL err_pulse got=%b exp=11", {div_err, div_busy});
    end
    step(1, 0, 0);
    checks++;
    if (div_err !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle got=%b exp=0", div_err);
    end
    guard = 0;
    while (div_busy === 1'b1 && guard < 20) begin
      step(1, 0, 0);
      guard++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL last_wins_wait got=%b exp=%b", got_vec(), exp_vec());
      end
    end
    gap = 0;
    do begin
      step(1, 0, 0);
      gap++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL last_wins_run got=%b exp=%b", got_vec(), exp_vec());
      end
    end while (tick !== 1'b1 && gap < 20);
    checks++;
    if (gap !== 6) begin
      failures++;
      $display("FAIL last_wins_period got=%0d exp=6", gap);
    end
  endtask

  task automatic test_en_pause();
    int guard, edges;
    step(1, 1, 5);
    guard = 0;
    while (div_busy === 1'b1 && guard < 20) begin
      step(1, 0, 0);
      guard++;
    end
    step(1, 0, 0);
    step(1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, c == 1, 3);
      checks++;
      if (got_vec() !== exp_vec() || tick !== 1'b0) begin
        failures++;
        $display("FAIL en_hold cyc=%0d got=%b exp=%b", c, got_vec(), exp_vec());
      end
    end
    checks++;
    if (div_busy !== 1'b1) begin
      failures++;
      $display("FAIL en_load_pending got=%b exp=1", div_busy);
    end
    edges = 0;
    while (div_busy === 1'b1 && edges < 10) begin
      step(1, 0, 0);
      edges++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_resume got=%b exp=%b", got_vec(), exp_vec());
      end
    end
    checks++;
    if (edges !== 3) begin
      failures++;
      $display("FAIL en_resume_edges got=%0d exp=3", edges);
    end
  endtask

  task automatic test_random();
    bit e, ld;
    int v;
    for (int c = 0; c < 400; c++) begin
      e  = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 9) == 0);
      v  = $urandom_range(0, 12);
      step(e, ld, v);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", c, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 7);
    step(1, 0, 0);
    step(1, 0, 0);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (got_vec() !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", got_vec(), {(STAGES+4){1'b0}});
    end
    model_reset();
    #2 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", c, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load5();
    test_sweep();
    test_last_wins();
    test_en_pause();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised clock-enable divider: successor to the fixed div2/div4/div8 divider.
- Keeps a vector of power-of-two divided outputs of configurable depth.
- Adds a runtime-programmable integer divider (odd or even ratio) with glitch-free ratio change at period boundaries, a count-enable, a wrap tick and a load handshake.
- Feeds slow-domain strobes and test clocks in lesson designs; all outputs are registered in the clk domain.

Parameters:
- WIDTH, 8, width of divisor and divide counter; legal ratios 2..2^WIDTH-1.
- STAGES, 3, number of power-of-two outputs; clk_pow2[i] has period 2^(i+1) clk cycles.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; 0 freezes all counters and outputs.
- div_val  input  WIDTH  requested divide ratio N.
- div_load  input  1  one-cycle request to load div_val.
- div_busy  output  1  a loaded ratio is pending, not yet applied.
- div_err  output  1  one-cycle pulse: load rejected (div_val < 2).
- clk_div  output  1  divided output, period N cycles.
- tick  output  1  one-cycle pulse per completed divide period.
- clk_pow2  output  STAGES  power-of-two divided outputs.

Behaviour:
- Reset (reset=0, asynchronous), all values:
  - pow_cnt=0, cnt=0, cur_div=2, pend_div=2.
  - div_busy=0, div_err=0, clk_div=0, tick=0, clk_pow2=0.
  - Release is synchronous to the next posedge; the first enabled edge after release counts.
- Power-of-two chain:
  - pow_cnt, STAGES bits, increments modulo 2^STAGES on each en=1 edge.
  - clk_pow2 = pow_cnt (registered); bit i toggles every 2^i enabled cycles.
- Programmable divider, N = cur_div:
  - cnt counts 0..N-1 on en=1 edges and wraps to 0 after N-1.
  - clk_div is a flop loaded from the next cnt value: 0 while cnt < floor(N/2), 1 otherwise.
  - Result: low floor(N/2) cycles, high ceil(N/2) cycles. N=3 gives 0,1,1; N=2 gives 0,1.
  - tick is registered: tick <= en && (cnt == N-1). It is high for exactly the one cycle after each wrap edge.
- Load handshake:
  - div_load=1 with div_val>=2: pend_div<=div_val, div_busy<=1 at that edge.
  - The new ratio is applied at the first wrap edge strictly after capture: cur_div<=pend_div, cnt<=0, div_busy<=0.
  - Until then the old ratio runs to completion. No truncated or stretched period; glitch-free.
  - Load while busy: pend_div is overwritten (last wins); busy stays 1.
  - Load on the same edge as a wrap: the wrap uses the old pending state. The new value is captured and applied at the following wrap.
  - div_load with div_val<2: ignored (pend_div, div_busy unchanged); div_err=1 for one cycle.
  - div_load is accepted regardless of en.
- en=0:
  - cnt, pow_cnt, clk_div and clk_pow2 hold; tick=0.
  - No ratio is applied, because no wrap occurs.
- Reset mid-operation: asynchronous clear to the reset values above; any pending ratio is discarded.
- Width rule: comparisons are unsigned WIDTH-bit. N-1 cannot underflow because N>=2 always.

Test Plan:
- Reset asserted 3 cycles then released, en=1, no load:
  - clk_pow2 runs 000,001,010,...,111,000.
  - clk_div toggles every cycle (N=2).
  - tick is high every second cycle, first at cycle 2 after release.
- Load div_val=5 at cycle 0 with en=1:
  - div_busy=1 until the next wrap, then drops.
  - clk_div then repeats 0,0,1,1,1 with period 5.
  - tick occurs every 5 cycles.
- Odd/even sweep with N=3,4,7:
  - Low/high counts are 1/2, 2/2 and 3/4 respectively.
  - Period is exact over 10 periods for each N.
- Load 9 then load 6 before the wrap:
  - pend_div=6 and 9 is never applied.
  - Load div_val=1: div_err pulses 1 cycle; ratio is unchanged and busy is unaffected.
- Toggle en low for 4 cycles mid-period, with N=5 and cnt=2:
  - All outputs hold and tick=0.
  - Counting resumes from cnt=3 when en returns.
  - Load issued while en=0 stays pending until the next wrap.
- Assert reset mid-period while busy:
  - Outputs go to 0 asynchronously, before the next posedge.
  - After release N=2 and div_busy=0.
